reg16_write_arbiter: RTL and testbench
======================================

# reg16_write_arbiter

Round-robin write-port arbiter that shares one 16-bit load-enabled register among several requesters. It accepts one write per clock from the winning requester and drives the register's LOAD and IN inputs from registered outputs. It returns a one-cycle grant/acknowledge to the winner. An optional per-requester LOCK gives the winner a bounded burst of back-to-back writes.

## Interface

Parameters:

- N_REQ, 4: number of requesters (2..8).
- WIDTH, 16: data width; matches the shared register.
- LOCK_MAX, 8: maximum consecutive grants one locked owner may take (≥1).

Ports:

- CLK  in  1  rising-edge clock; the only clock.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  N_REQ  per-requester write request, level.
- LOCK  in  N_REQ  per-requester burst-lock qualifier; only meaningful with REQ.
- WDATA  in  N_REQ*WIDTH  write data; requester i drives bits [i*WIDTH +: WIDTH].
- GNT  out  N_REQ  one-hot, registered, single-cycle acknowledge that requester's write was taken.
- LOAD  out  1  load enable to the shared register, registered.
- IN  out  WIDTH  data to the shared register, registered.
- OWNER  out  clog2(N_REQ)  index of the most recently granted requester.
- BUSY  out  1  high while a lock owner holds the port.

## Operation

- **States:** IDLE (open arbitration) and LOCKED (only OWNER is eligible).
- **Internal state:**
  - round-robin pointer PTR, where priority starts.
  - beat counter BEATS, width clog2(LOCK_MAX)+1.
- **IDLE:**
  - The first i with REQ[i]=1, scanning PTR, PTR+1, … mod N_REQ, wins.
  - On a win: GNT[i]←1, LOAD←1, IN←WDATA slice i, OWNER←i, PTR←(i+1) mod N_REQ.
  - If LOCK[i]=1 at the win, go to LOCKED with BEATS←1; otherwise stay in IDLE.
- **LOCKED:**
  - If REQ[OWNER]=1, LOCK[OWNER]=1 and BEATS<LOCK_MAX: grant OWNER again and increment BEATS. PTR is unchanged (already OWNER+1).
  - If REQ[OWNER]=0 or LOCK[OWNER]=0: release and go to IDLE. IDLE arbitration among all requesters runs in the same cycle, so there is no dead cycle. If OWNER still has REQ=1 with LOCK=0, it competes at lowest priority.
  - If BEATS=LOCK_MAX: forced release. Same-cycle IDLE arbitration runs with OWNER excluded for that cycle.
- **No winner:** GNT←0 and LOAD←0. IN holds its last value, and OWNER holds.
- **Requester obligations:**
  - Hold REQ and WDATA stable until GNT is seen.
  - REQ still high in the GNT cycle counts as the next write request.
  - Data is sampled on the granting edge.
- BUSY is high exactly while the state is LOCKED.
- **Invariants:** GNT is zero or one-hot; LOAD equals OR of GNT.

## Timing

- **Reset (RESET=0, asynchronous):**
  - Outputs: GNT=0, LOAD=0, IN=0, OWNER=0, BUSY=0.
  - Internal: PTR=0, BEATS=0, state IDLE.
  - A write pending in the same cycle is dropped; no LOAD is issued.
- **Deassertion:** the first edge after deassertion arbitrates normally from PTR=0.
- **Latency:**
  - REQ sampled at edge k; GNT, LOAD and IN are valid after edge k.
  - The shared register holds the new value after edge k+1.
- **Throughput:** one write per cycle, sustained.
- **Lock lifetime:** a single lock owner receives at most LOCK_MAX consecutive grants. Under full load, a non-locking requester waits at most (N_REQ−1)·LOCK_MAX cycles.

## Test plan

- **Reset mid-traffic:** all REQ=1, RESET pulled low between edges → GNT=0, LOAD=0, IN=0, BUSY=0 immediately. After release, the first grant is to requester 0.
- **Single write:** REQ=4'b0100, WDATA slice 2=16'hBEEF → after the next edge: GNT=4'b0100, LOAD=1, IN=16'hBEEF, OWNER=2. The register reads 16'hBEEF one edge later.
- **Round robin:** REQ=4'b1111 held for 8 cycles, LOCK=0 → grant order 0,1,2,3,0,1,2,3 with LOAD=1 every cycle.
- **Lock limit:** REQ=4'b0111, LOCK=4'b0010, LOCK_MAX=8, starting at PTR=1 → 8 consecutive grants to 1 with BUSY=1, then grants to 2 and then 0 with BUSY=0.
- **Lock early release:** requester 3 locked for 3 beats, then REQ[3]=0 in the same cycle as REQ[0]=1 → requester 0 is granted on that edge with no idle cycle, and BUSY falls.
- **Idle hold:** REQ=0 for 5 cycles after a write of 16'h1234 → LOAD=0 and GNT=0 throughout; IN stays 16'h1234 and OWNER is unchanged.

Source files
------------

// File: rtl/reg16_write_arbiter.sv
// Round-robin write-port arbiter for one shared load-enabled register.
// One registered write per clock; an optional per-requester lock grants bounded bursts.
module reg16_write_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LOCK_MAX = 8,
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned BW = $clog2(LOCK_MAX) + 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         LOCK,
  input  logic [N_REQ*WIDTH-1:0]   WDATA,
  output logic [N_REQ-1:0]         GNT,
  output logic                     LOAD,
  output logic [WIDTH-1:0]         IN,
  output logic [OW-1:0]            OWNER,
  output logic                     BUSY
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     ptr, ptr_nxt;
  logic [OW-1:0]     owner_nxt;
  logic [BW-1:0]     beats, beats_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [N_REQ-1:0]  mask;
  logic              load_nxt;
  logic [WIDTH-1:0]  in_nxt;
  logic              hold;
  logic              found;
  logic [OW-1:0]     win;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    beats_nxt = beats;
    owner_nxt = OWNER;
    gnt_nxt   = '0;
    load_nxt  = 1'b0;
    in_nxt    = IN;
    mask      = REQ;
    found     = 1'b0;
    win       = '0;
    hold      = (state == LOCKED) && REQ[OWNER] && LOCK[OWNER] &&
                (beats < BW'(LOCK_MAX));

    if (hold) begin
      gnt_nxt[OWNER] = 1'b1;
      load_nxt       = 1'b1;
      in_nxt         = WDATA[OWNER*WIDTH +: WIDTH];
      beats_nxt      = beats + 1'b1;
    end else begin
      // Release falls straight into open arbitration so no cycle is lost;
      // a burst that hit its limit sits this round out.
      if ((state == LOCKED) && (beats >= BW'(LOCK_MAX)))
        mask[OWNER] = 1'b0;
      state_nxt = IDLE;
      beats_nxt = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!found && mask[(32'(ptr) + k) % N_REQ]) begin
          found = 1'b1;
          win   = OW'((32'(ptr) + k) % N_REQ);
        end
      end
      if (found) begin
        gnt_nxt[win] = 1'b1;
        load_nxt     = 1'b1;
        in_nxt       = WDATA[win*WIDTH +: WIDTH];
        owner_nxt    = win;
        ptr_nxt      = (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        if (LOCK[win]) begin
          state_nxt = LOCKED;
          beats_nxt = BW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      ptr   <= '0;
      beats <= '0;
      GNT   <= '0;
      LOAD  <= 1'b0;
      IN    <= '0;
      OWNER <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      beats <= beats_nxt;
      GNT   <= gnt_nxt;
      LOAD  <= load_nxt;
      IN    <= in_nxt;
      OWNER <= owner_nxt;
    end
  end

  assign BUSY = (state == LOCKED);

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Directed bench for reg16_write_arbiter: reset, single write, round robin,
// lock limit, early lock release and idle hold.
module tb_reg16_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  REQ;
  logic [3:0]  LOCK;
  logic [63:0] WDATA;
  logic [3:0]  GNT;
  logic        LOAD;
  logic [15:0] IN;
  logic [1:0]  OWNER;
  logic        BUSY;
  logic [15:0] shreg;

  int total = 0;
  int bad   = 0;

  reg16_write_arbiter #(.N_REQ(4), .WIDTH(16), .LOCK_MAX(8)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LOCK(LOCK), .WDATA(WDATA),
    .GNT(GNT), .LOAD(LOAD), .IN(IN), .OWNER(OWNER), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the shared register fed by LOAD/IN.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) shreg <= '0;
    else if (LOAD) shreg <= IN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic l,
                         input logic [15:0] d, input logic [1:0] o, input logic b);
    chk({tag, "_gnt"},   32'(GNT),   32'(g));
    chk({tag, "_load"},  32'(LOAD),  32'(l));
    chk({tag, "_in"},    32'(IN),    32'(d));
    chk({tag, "_owner"}, 32'(OWNER), 32'(o));
    chk({tag, "_busy"},  32'(BUSY),  32'(b));
    chk({tag, "_loadgnt"}, 32'(LOAD), 32'(|GNT));
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    REQ   = '0;
    LOCK  = '0;
    WDATA = '0;
    #1;
    chk_out("reset", 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    #11;
    RESET = 1'b1;

    // single write from requester 2
    REQ = 4'b0100;
    WDATA[2*16 +: 16] = 16'hBEEF;
    step;
    chk_out("single", 4'b0100, 1'b1, 16'hBEEF, 2'd2, 1'b0);
    REQ = 4'b0000;
    step;
    chk_out("single_after", 4'b0000, 1'b0, 16'hBEEF, 2'd2, 1'b0);
    chk("single_shreg", 32'(shreg), 32'h0000BEEF);

    // reset mid-traffic, then round robin from requester 0
    REQ   = 4'b1111;
    WDATA = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    step;
    chk_out("pre_rst", 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    chk_out("rst_mid", 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
    #2;
    RESET = 1'b1;
    step; chk_out("rr0", 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b0);
    step; chk_out("rr1", 4'b0010, 1'b1, 16'hA001, 2'd1, 1'b0);
    step; chk_out("rr2", 4'b0100, 1'b1, 16'hA002, 2'd2, 1'b0);
    step; chk_out("rr3", 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b0);
    step; chk_out("rr4", 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b0);
    step; chk_out("rr5", 4'b0010, 1'b1, 16'hA001, 2'd1, 1'b0);
    step; chk_out("rr6", 4'b0100, 1'b1, 16'hA002, 2'd2, 1'b0);
    step; chk_out("rr7", 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b0);

    // move pointer to 1, then lock limit on requester 1
    REQ = 4'b0001;
    step;
    chk_out("ptr_to1", 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b0);
    REQ  = 4'b0111;
    LOCK = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step;
      chk_out($sformatf("lock_beat%0d", i), 4'b0010, 1'b1, 16'hA001, 2'd1, 1'b1);
    end
    step; chk_out("lock_rel2", 4'b0100, 1'b1, 16'hA002, 2'd2, 1'b0);
    step; chk_out("lock_rel0", 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b0);

    // requester 3 locks for three beats, then drops as requester 0 asks
    REQ  = 4'b1000;
    LOCK = 4'b1000;
    step; chk_out("early_b0", 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1);
    step; chk_out("early_b1", 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1);
    step; chk_out("early_b2", 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1);
    REQ  = 4'b0001;
    LOCK = 4'b0000;
    step; chk_out("early_rel", 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b0);

    // write 16'h1234 then idle for five cycles
    REQ = 4'b0010;
    WDATA[1*16 +: 16] = 16'h1234;
    step; chk_out("idle_wr", 4'b0010, 1'b1, 16'h1234, 2'd1, 1'b0);
    REQ = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step;
      chk_out($sformatf("idle%0d", i), 4'b0000, 1'b0, 16'h1234, 2'd1, 1'b0);
    end
    chk("idle_shreg", 32'(shreg), 32'h00001234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
